adc_scan_spi: RTL

- Parametrised SPI master for MCP300x-class successive-approximation ADCs.
- Autonomously scans a programmable set of single-ended or differential channels.
- Publishes each result with a one-cycle valid strobe and keeps a per-channel result bank.
- Replaces hand-sequenced, single-channel ADC bit-banging in motor-control tops; throttle, current and bus-voltage readings all come from one block.

---
 rtl/adc_scan_spi.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/adc_scan_spi.sv
// SPI master that round-robins over a mask of MCP300x ADC channels,
// strobing each conversion result and keeping a per-channel result bank.
module adc_scan_spi #(
  parameter int unsigned CLK_DIV  = 27,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ADC_BITS = 10,
  parameter int unsigned SGL      = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          ch_mask,
  output logic                       sclk,
  output logic                       cs_n,
  output logic                       mosi,
  input  logic                       miso,
  output logic [ADC_BITS-1:0]        sample_data,
  output logic [2:0]                 sample_ch,
  output logic                       sample_valid,
  output logic [NUM_CH*ADC_BITS-1:0] ch_data,
  output logic                       busy
);

  localparam int unsigned N     = ADC_BITS + 7;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCLK_HI, SCLK_LO, GAP} state_t;

  state_t              state;
  logic [DIV_W-1:0]    div;
  logic [CNT_W-1:0]    rise_cnt;
  logic [2:0]          ptr;
  logic [2:0]          sel;
  logic [3:0]          cmd_sh;
  logic [ADC_BITS-1:0] shreg;
  logic                gap_half;

  logic [7:0]          mask8_c;
  logic [3:0]          idx_c;
  logic [2:0]          next_sel_c;
  logic                found_c;
  logic                half_done_c;

  assign half_done_c = (div == DIV_W'(CLK_DIV - 1));

  // First set mask bit at or after the scan pointer, wrapping modulo NUM_CH.
  always_comb begin
    mask8_c    = 8'(ch_mask);
    idx_c      = '0;
    next_sel_c = '0;
    found_c    = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      idx_c = 4'(ptr) + 4'(i);
      if (idx_c >= 4'(NUM_CH)) idx_c = idx_c - 4'(NUM_CH);
      if (mask8_c[idx_c[2:0]]) begin
        next_sel_c = idx_c[2:0];
        found_c    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      div          <= '0;
      rise_cnt     <= '0;
      ptr          <= '0;
      sel          <= '0;
      cmd_sh       <= '0;
      shreg        <= '0;
      gap_half     <= 1'b0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      mosi         <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      ch_data      <= '0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          div <= '0;
          if (enable && found_c) begin
            cs_n     <= 1'b0;
            mosi     <= 1'b1;
            busy     <= 1'b1;
            sel      <= next_sel_c;
            cmd_sh   <= {1'(SGL), next_sel_c};
            rise_cnt <= '0;
            state    <= SETUP;
          end
        end
        // Rising edge: data bits arrive from rise 8 onward.
        SETUP, SCLK_LO: begin
          if (half_done_c) begin
            div      <= '0;
            sclk     <= 1'b1;
            rise_cnt <= rise_cnt + 1'b1;
            if (rise_cnt >= CNT_W'(7)) shreg <= {shreg[ADC_BITS-2:0], miso};
            state    <= SCLK_HI;
          end else begin
            div <= div + 1'b1;
          end
        end
        // Falling edge: present next command bit, or close the frame.
        SCLK_HI: begin
          if (half_done_c) begin
            div  <= '0;
            sclk <= 1'b0;
            if (rise_cnt == CNT_W'(N)) begin
              cs_n         <= 1'b1;
              mosi         <= 1'b0;
              sample_valid <= 1'b1;
              sample_data  <= shreg;
              sample_ch    <= sel;
              for (int i = 0; i < int'(NUM_CH); i++) begin
                if (sel == 3'(i)) ch_data[i*ADC_BITS +: ADC_BITS] <= shreg;
              end
              ptr      <= (sel == 3'(NUM_CH - 1)) ? 3'd0 : sel + 3'd1;
              gap_half <= 1'b0;
              state    <= GAP;
            end else begin
              mosi   <= cmd_sh[3];
              cmd_sh <= {cmd_sh[2:0], 1'b0};
              state  <= SCLK_LO;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        // Two half-periods of CS-high time before the next selection.
        GAP: begin
          if (half_done_c) begin
            div <= '0;
            if (gap_half) begin
              gap_half <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              gap_half <= 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
